// File: rtl/func_hdl_tx_serializer_if.sv
// Stream bundle for the TX serializer: wide packed-record input side and narrow word output side.
// The master view belongs to the serializer; the slave view belongs to whatever feeds and drains it.
interface func_hdl_tx_serializer_if #(
    parameter int unsigned C_WORD_WIDTH = 32,
    parameter int unsigned C_NFIELDS    = 4,
    parameter int unsigned C_DATA_WIDTH = C_WORD_WIDTH * C_NFIELDS
) ();
    logic                    s_tvalid;
    logic [C_DATA_WIDTH-1:0] s_tdata;
    logic                    s_tready;
    logic                    m_tvalid;
    logic [C_WORD_WIDTH-1:0] m_tdata;
    logic                    m_tlast;
    logic                    m_tready;

    modport master (
        input  s_tvalid, s_tdata, m_tready,
        output s_tready, m_tvalid, m_tdata, m_tlast
    );

    modport slave (
        output s_tvalid, s_tdata, m_tready,
        input  s_tready, m_tvalid, m_tdata, m_tlast
    );
endinterface

// File: rtl/func_hdl_tx_serializer.sv
// Width downsizer: one packed record in, C_NFIELDS words out, field 0 first.
// Define TY_TX_FRAME_TLAST_EN to assert m_tlast once per C_FRAME_LEN records instead of per record.
module func_hdl_tx_serializer #(
    parameter int unsigned C_WORD_WIDTH = 32,
    parameter int unsigned C_NFIELDS    = 4,
    parameter int unsigned C_DATA_WIDTH = C_WORD_WIDTH * C_NFIELDS,
    parameter int unsigned C_FRAME_LEN  = 1024
) (
    input  logic                     aclk,
    input  logic                     areset,
    func_hdl_tx_serializer_if.master bus
);
    localparam int unsigned      IDX_W    = $clog2(C_NFIELDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C_NFIELDS - 1);

    logic [C_DATA_WIDTH-1:0] hold;
    logic                    hold_valid;
    logic [IDX_W-1:0]        idx;
    logic [C_WORD_WIDTH-1:0] fields [C_NFIELDS];
    logic                    at_last_c;
    logic                    in_hs_c;
    logic                    out_hs_c;

    for (genvar i = 0; i < C_NFIELDS; i++) begin : g_field
        assign fields[i] = hold[i*C_WORD_WIDTH +: C_WORD_WIDTH];
    end

    assign at_last_c = hold_valid && (idx == LAST_IDX);
    assign out_hs_c  = hold_valid && bus.m_tready;
    // Accept a new record while empty, or in the same cycle the last field leaves.
    assign bus.s_tready = !hold_valid || (bus.m_tready && idx == LAST_IDX);
    assign in_hs_c      = bus.s_tvalid && bus.s_tready;

    assign bus.m_tvalid = hold_valid;
    assign bus.m_tdata  = fields[idx];

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            hold       <= '0;
            hold_valid <= 1'b0;
            idx        <= '0;
        end else if (in_hs_c) begin
            hold       <= bus.s_tdata;
            hold_valid <= 1'b1;
            idx        <= '0;
        end else if (out_hs_c) begin
            if (idx == LAST_IDX) begin
                hold_valid <= 1'b0;
                idx        <= '0;
            end else begin
                idx <= idx + 1'b1;
            end
        end
    end

`ifdef TY_TX_FRAME_TLAST_EN
    localparam int unsigned      REC_W    = (C_FRAME_LEN > 1) ? $clog2(C_FRAME_LEN) : 1;
    localparam logic [REC_W-1:0] REC_LAST = REC_W'(C_FRAME_LEN - 1);

    logic [REC_W-1:0] rec_cnt;

    // Completed-record counter; wraps when the frame's final record leaves.
    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rec_cnt <= '0;
        end else if (out_hs_c && at_last_c) begin
            rec_cnt <= (rec_cnt == REC_LAST) ? '0 : rec_cnt + 1'b1;
        end
    end

    assign bus.m_tlast = at_last_c && (rec_cnt == REC_LAST);
`else
    assign bus.m_tlast = at_last_c;
`endif
endmodule

// File: tb/tb_func_hdl_tx_serializer.sv
// Directed and randomized checks of func_hdl_tx_serializer: latency, ordering, stalls, reset, tlast.
module tb_func_hdl_tx_serializer;
    localparam int unsigned W  = 32;
    localparam int unsigned NF = 4;
`ifdef TY_TX_FRAME_TLAST_EN
    localparam int unsigned FL = 3;
`else
    localparam int unsigned FL = 1024;
`endif
    localparam int N_RAND = 1000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_run    = 0;
    int   n_fail   = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    func_hdl_tx_serializer_if #(.C_WORD_WIDTH(W), .C_NFIELDS(NF), .C_DATA_WIDTH(W*NF)) bus ();

    func_hdl_tx_serializer #(
        .C_WORD_WIDTH(W), .C_NFIELDS(NF), .C_DATA_WIDTH(W*NF), .C_FRAME_LEN(FL)
    ) dut (
        .aclk  (clk),
        .areset(rst),
        .bus   (bus)
    );

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W*NF-1:0] mk_seq(input logic [W-1:0] base);
        logic [W*NF-1:0] v;
        v = '0;
        for (int f = 0; f < int'(NF); f++) v[f*W +: W] = base + W'(f);
        return v;
    endfunction

    // Expected tlast for a beat, given how many records have completed since reset.
    function automatic logic exp_last(input logic last_field);
`ifdef TY_TX_FRAME_TLAST_EN
        return last_field && ((done_cnt % int'(FL)) == int'(FL) - 1);
`else
        return last_field;
`endif
    endfunction

    task automatic test_reset();
        rst = 1'b1; bus.s_tvalid = 1'b0; bus.s_tdata = '0; bus.m_tready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_run++; if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL reset_m_tvalid: got %b expected 0", bus.m_tvalid); end
        n_run++; if (bus.m_tdata !== '0) begin n_fail++; $display("FAIL reset_m_tdata: got %h expected 0", bus.m_tdata); end
        n_run++; if (bus.m_tlast !== 1'b0) begin n_fail++; $display("FAIL reset_m_tlast: got %b expected 0", bus.m_tlast); end
        n_run++; if (bus.s_tready !== 1'b1) begin n_fail++; $display("FAIL reset_s_tready: got %b expected 1", bus.s_tready); end
        rst = 1'b0; done_cnt = 0;
    endtask

    task automatic test_single();
        bus.m_tready = 1'b1; bus.s_tvalid = 1'b1; bus.s_tdata = mk_seq(32'd1);
        #1;
        n_run++; if (bus.s_tready !== 1'b1) begin n_fail++; $display("FAIL single_s_tready: got %b expected 1", bus.s_tready); end
        cyc();
        bus.s_tvalid = 1'b0;
        for (int i = 0; i < int'(NF); i++) begin
            #1;
            n_run++; if (bus.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL single_m_tvalid beat %0d: got %b expected 1", i, bus.m_tvalid); end
            n_run++; if (bus.m_tdata !== W'(i + 1)) begin n_fail++; $display("FAIL single_m_tdata beat %0d: got %h expected %h", i, bus.m_tdata, W'(i + 1)); end
            n_run++; if (bus.m_tlast !== exp_last(i == int'(NF) - 1)) begin n_fail++; $display("FAIL single_m_tlast beat %0d: got %b expected %b", i, bus.m_tlast, exp_last(i == int'(NF) - 1)); end
            if (i == int'(NF) - 1) done_cnt++;
            cyc();
        end
        #1;
        n_run++; if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL single_idle: got m_tvalid %b expected 0", bus.m_tvalid); end
        cyc();
    endtask

    task automatic test_back_to_back();
        int  sent;
        logic exp_rdy, exp_vld;
        int  r, f;
        sent = 0;
        bus.m_tready = 1'b1;
        for (int c = 0; c <= 33; c++) begin
            bus.s_tvalid = (sent < 8);
            bus.s_tdata  = mk_seq(W'(32'h1000 + sent * 16));
            #1;
            exp_rdy = (c == 0) || (c == 33) || (((c - 1) % 4) == 3);
            exp_vld = (c >= 1) && (c <= 32);
            n_run++; if (bus.s_tready !== exp_rdy) begin n_fail++; $display("FAIL b2b_s_tready cycle %0d: got %b expected %b", c, bus.s_tready, exp_rdy); end
            n_run++; if (bus.m_tvalid !== exp_vld) begin n_fail++; $display("FAIL b2b_m_tvalid cycle %0d: got %b expected %b", c, bus.m_tvalid, exp_vld); end
            if (exp_vld) begin
                r = (c - 1) / 4; f = (c - 1) % 4;
                n_run++; if (bus.m_tdata !== W'(32'h1000 + r * 16 + f)) begin n_fail++; $display("FAIL b2b_m_tdata cycle %0d: got %h expected %h", c, bus.m_tdata, W'(32'h1000 + r * 16 + f)); end
                n_run++; if (bus.m_tlast !== exp_last(f == 3)) begin n_fail++; $display("FAIL b2b_m_tlast cycle %0d: got %b expected %b", c, bus.m_tlast, exp_last(f == 3)); end
                if (f == 3) done_cnt++;
            end
            if (bus.s_tvalid && bus.s_tready) sent++;
            cyc();
        end
        bus.s_tvalid = 1'b0;
        n_run++; if (sent != 8) begin n_fail++; $display("FAIL b2b_records_accepted: got %0d expected 8", sent); end
    endtask

    task automatic test_sink_stall();
        bus.m_tready = 1'b1; bus.s_tvalid = 1'b1; bus.s_tdata = mk_seq(32'd1);
        cyc();
        bus.s_tvalid = 1'b0;
        #1;
        n_run++; if (bus.m_tdata !== W'(1)) begin n_fail++; $display("FAIL stall_first: got %h expected 1", bus.m_tdata); end
        cyc();
        bus.m_tready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_run++; if (bus.m_tdata !== W'(2)) begin n_fail++; $display("FAIL stall_m_tdata cycle %0d: got %h expected 2", i, bus.m_tdata); end
            n_run++; if (bus.m_tvalid !== 1'b1) begin n_fail++; $display("FAIL stall_m_tvalid cycle %0d: got %b expected 1", i, bus.m_tvalid); end
            n_run++; if (bus.s_tready !== 1'b0) begin n_fail++; $display("FAIL stall_s_tready cycle %0d: got %b expected 0", i, bus.s_tready); end
            cyc();
        end
        bus.m_tready = 1'b1;
        for (int i = 2; i <= 4; i++) begin
            #1;
            n_run++; if (bus.m_tdata !== W'(i)) begin n_fail++; $display("FAIL stall_resume word %0d: got %h expected %h", i, bus.m_tdata, W'(i)); end
            n_run++; if (bus.m_tlast !== exp_last(i == 4)) begin n_fail++; $display("FAIL stall_m_tlast word %0d: got %b expected %b", i, bus.m_tlast, exp_last(i == 4)); end
            if (i == 4) done_cnt++;
            cyc();
        end
    endtask

    task automatic test_reset_mid_record();
        bus.m_tready = 1'b1; bus.s_tvalid = 1'b1; bus.s_tdata = mk_seq(32'h11);
        cyc();
        bus.s_tvalid = 1'b0;
        #1;
        n_run++; if (bus.m_tdata !== W'(32'h11)) begin n_fail++; $display("FAIL rstmid_beat1: got %h expected 11", bus.m_tdata); end
        cyc();
        #1;
        n_run++; if (bus.m_tdata !== W'(32'h12)) begin n_fail++; $display("FAIL rstmid_beat2: got %h expected 12", bus.m_tdata); end
        cyc();
        rst = 1'b1;
        #1;
        n_run++; if (bus.m_tvalid !== 1'b0) begin n_fail++; $display("FAIL rstmid_m_tvalid: got %b expected 0", bus.m_tvalid); end
        n_run++; if (bus.m_tdata !== '0) begin n_fail++; $display("FAIL rstmid_m_tdata: got %h expected 0", bus.m_tdata); end
        n_run++; if (bus.s_tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_s_tready: got %b expected 1", bus.s_tready); end
        cyc();
        rst = 1'b0; done_cnt = 0;
        bus.s_tvalid = 1'b1; bus.s_tdata = mk_seq(32'h55);
        #1;
        n_run++; if (bus.s_tready !== 1'b1) begin n_fail++; $display("FAIL rstmid_release_s_tready: got %b expected 1", bus.s_tready); end
        cyc();
        bus.s_tvalid = 1'b0;
        for (int i = 0; i < int'(NF); i++) begin
            #1;
            n_run++; if (bus.m_tdata !== W'(32'h55 + i)) begin n_fail++; $display("FAIL rstmid_next word %0d: got %h expected %h", i, bus.m_tdata, W'(32'h55 + i)); end
            if (i == int'(NF) - 1) done_cnt++;
            cyc();
        end
    endtask

`ifdef TY_TX_FRAME_TLAST_EN
    task automatic test_frame_tlast();
        int sent;
        rst = 1'b1;
        cyc();
        rst = 1'b0; done_cnt = 0; sent = 0;
        bus.m_tready = 1'b1;
        for (int c = 0; c <= 25; c++) begin
            bus.s_tvalid = (sent < 6);
            bus.s_tdata  = mk_seq(W'(32'h2000 + sent * 16));
            #1;
            if (c >= 1 && c <= 24) begin
                n_run++; if (bus.m_tlast !== ((c == 12) || (c == 24))) begin n_fail++; $display("FAIL frame_m_tlast beat %0d: got %b expected %b", c, bus.m_tlast, ((c == 12) || (c == 24))); end
            end
            if (bus.s_tvalid && bus.s_tready) sent++;
            cyc();
        end
        bus.s_tvalid = 1'b0;
        done_cnt = 6;
    endtask
`endif

    task automatic test_random();
        logic [W-1:0]    q [$];
        logic [W*NF-1:0] d;
        logic            exp_rdy, acc;
        int              sent, cycles;
        sent = 0; cycles = 0;
        bus.s_tvalid = 1'b0;
        while ((sent < N_RAND || q.size() != 0) && cycles < 30000) begin
            if (!bus.s_tvalid && sent < N_RAND && $urandom_range(0, 1) == 1) begin
                bus.s_tvalid = 1'b1;
                for (int f = 0; f < int'(NF); f++) d[f*W +: W] = $urandom;
                bus.s_tdata = d;
            end
            bus.m_tready = ($urandom_range(0, 3) != 0);
            #1;
            exp_rdy = (q.size() == 0) || (bus.m_tready && q.size() == 1);
            n_run++; if (bus.s_tready !== exp_rdy) begin n_fail++; $display("FAIL rand_s_tready cycle %0d: got %b expected %b", cycles, bus.s_tready, exp_rdy); end
            n_run++; if (bus.m_tvalid !== (q.size() != 0)) begin n_fail++; $display("FAIL rand_m_tvalid cycle %0d: got %b expected %b", cycles, bus.m_tvalid, (q.size() != 0)); end
            if (q.size() != 0) begin
                n_run++; if (bus.m_tdata !== q[0]) begin n_fail++; $display("FAIL rand_m_tdata cycle %0d: got %h expected %h", cycles, bus.m_tdata, q[0]); end
                n_run++; if (bus.m_tlast !== exp_last(q.size() == 1)) begin n_fail++; $display("FAIL rand_m_tlast cycle %0d: got %b expected %b", cycles, bus.m_tlast, exp_last(q.size() == 1)); end
                if (bus.m_tready) begin
                    if (q.size() == 1) done_cnt++;
                    void'(q.pop_front());
                end
            end
            acc = bus.s_tvalid && exp_rdy;
            if (acc) begin
                d = bus.s_tdata;
                for (int f = 0; f < int'(NF); f++) q.push_back(d[f*W +: W]);
                sent++;
            end
            cyc();
            if (acc) bus.s_tvalid = 1'b0;
            cycles++;
        end
        bus.s_tvalid = 1'b0;
        n_run++; if (sent != N_RAND || q.size() != 0) begin n_fail++; $display("FAIL rand_complete: got %0d records sent, %0d words pending; expected %0d sent, 0 pending", sent, q.size(), N_RAND); end
    endtask

    initial begin
        test_reset();
        cyc();
        test_single();
        test_back_to_back();
        test_sink_stall();
        test_reset_mid_record();
`ifdef TY_TX_FRAME_TLAST_EN
        test_frame_tlast();
`endif
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
